// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the response consumer
// and alu_arbiter.
interface alu_arbiter_if;
    logic [1:0] req_vld;
    logic [1:0] req_rdy;
    logic [1:0] cmd0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [1:0] cmd1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       rsp_vld;
    logic       rsp_rdy;
    logic       rsp_id;
    logic [7:0] rsp_rslt;
    logic       rsp_zero;
    logic       rsp_pari;
    logic       rsp_neq;
    logic       busy;

    modport master (
        output req_vld, cmd0, a0, b0, cmd1, a1, b1, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_id, rsp_rslt, rsp_zero, rsp_pari, rsp_neq, busy
    );

    modport slave (
        input  req_vld, cmd0, a0, b0, cmd1, a1, b1, rsp_rdy,
        output req_rdy, rsp_vld, rsp_id, rsp_rslt, rsp_zero, rsp_pari, rsp_neq, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 8-bit combinational ALU between two requesters,
// with registered operands and a single tagged response channel.
//
// state | meaning
// IDLE  | accept one granted request
// EXEC  | ALU evaluates the registered operands
// DONE  | response valid, waiting for the consumer

module alu8 (
    input  logic [1:0] cmd,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       sc_i,
    output logic [7:0] rslt,
    output logic       zero,
    output logic       pari,
    output logic       neq,
    output logic       sc_o
);
    always_comb begin
        rslt = 8'h00;
        sc_o = 1'b0;
        case (cmd)
            2'b10:   {sc_o, rslt} = {1'b0, in_a} + {1'b0, in_b} + {8'h00, sc_i};
            2'b01: begin
                rslt = {in_a[0], in_a[7:1]};
                sc_o = in_a[0];
            end
            2'b00:   rslt = ~(in_a & in_b);
            default: rslt = 8'h00;
        endcase
    end

    assign zero = (rslt == 8'h00);
    assign pari = ^rslt;
    assign neq  = (in_a != in_b);
endmodule

module alu_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] gnt;
    logic       ptr;
    logic       id_q;
    logic [1:0] cmd_q;
    logic [7:0] a_q;
    logic [7:0] b_q;

    logic       rsp_id_q;
    logic [7:0] rsp_rslt_q;
    logic       rsp_zero_q;
    logic       rsp_pari_q;
    logic       rsp_neq_q;

    logic [7:0] alu_rslt;
    logic       alu_zero;
    logic       alu_pari;
    logic       alu_neq;
    logic       alu_sc_o;

    // Flags are recomputed from the captured result, so the ALU's own are dropped.
    wire alu_unused = ^{alu_zero, alu_pari, alu_sc_o};

    alu8 u_alu (
        .cmd  (cmd_q),
        .in_a (a_q),
        .in_b (b_q),
        .sc_i (1'b0),
        .rslt (alu_rslt),
        .zero (alu_zero),
        .pari (alu_pari),
        .neq  (alu_neq),
        .sc_o (alu_sc_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = 2'b00;
        case (state)
            IDLE: begin
                gnt[0] = bus.req_vld[0] & (!ptr | !bus.req_vld[1]);
                gnt[1] = bus.req_vld[1] & ( ptr | !bus.req_vld[0]);
                if (|gnt) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = DONE;
            DONE: begin
                if (bus.rsp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= RR_INIT;
            id_q       <= 1'b0;
            cmd_q      <= 2'b00;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            rsp_id_q   <= 1'b0;
            rsp_rslt_q <= 8'h00;
            rsp_zero_q <= 1'b0;
            rsp_pari_q <= 1'b0;
            rsp_neq_q  <= 1'b0;
        end else begin
            if (state == IDLE && (|gnt)) begin
                if (gnt[1]) begin
                    cmd_q <= bus.cmd1;
                    a_q   <= bus.a1;
                    b_q   <= bus.b1;
                    id_q  <= 1'b1;
                    ptr   <= 1'b0;
                end else begin
                    cmd_q <= bus.cmd0;
                    a_q   <= bus.a0;
                    b_q   <= bus.b0;
                    id_q  <= 1'b0;
                    ptr   <= 1'b1;
                end
            end
            if (state == EXEC) begin
                rsp_rslt_q <= alu_rslt;
                rsp_neq_q  <= alu_neq;
                rsp_zero_q <= (alu_rslt == 8'h00);
                rsp_pari_q <= ^alu_rslt;
                rsp_id_q   <= id_q;
            end
        end
    end

    assign bus.req_rdy  = gnt;
    assign bus.rsp_vld  = (state == DONE);
    assign bus.busy     = (state != IDLE);
    assign bus.rsp_id   = rsp_id_q;
    assign bus.rsp_rslt = rsp_rslt_q;
    assign bus.rsp_zero = rsp_zero_q;
    assign bus.rsp_pari = rsp_pari_q;
    assign bus.rsp_neq  = rsp_neq_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single operations plus
// hand-written round-robin, back-pressure and mid-operation reset sequences.
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    alu_arbiter_if bus ();

    alu_arbiter #(.RR_INIT(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         id;
        logic [1:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] rslt;
        logic       zero;
        logic       pari;
        logic       neq;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_op(input vec_t v);
        bus.rsp_rdy = 1'b0;
        if (v.id) begin
            bus.cmd1 = v.cmd;  bus.a1 = v.a;  bus.b1 = v.b;
            bus.cmd0 = ~v.cmd; bus.a0 = ~v.a; bus.b0 = v.a;
            bus.req_vld = 2'b10;
        end else begin
            bus.cmd0 = v.cmd;  bus.a0 = v.a;  bus.b0 = v.b;
            bus.cmd1 = ~v.cmd; bus.a1 = ~v.a; bus.b1 = v.a;
            bus.req_vld = 2'b01;
        end
        #1;
        chk("op_req_rdy", bus.req_rdy, v.id ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        bus.req_vld = 2'b00;
        chk("op_exec_busy", bus.busy, 1'b1);
        chk("op_exec_vld", bus.rsp_vld, 1'b0);
        @(posedge clk); #1;
        chk("op_rsp_vld", bus.rsp_vld, 1'b1);
        chk("op_rsp_id", bus.rsp_id, v.id);
        chk("op_rsp_rslt", bus.rsp_rslt, v.rslt);
        chk("op_rsp_zero", bus.rsp_zero, v.zero);
        chk("op_rsp_pari", bus.rsp_pari, v.pari);
        chk("op_rsp_neq", bus.rsp_neq, v.neq);
        bus.rsp_rdy = 1'b1;
        @(posedge clk); #1;
        bus.rsp_rdy = 1'b0;
        chk("op_handoff_vld", bus.rsp_vld, 1'b0);
        chk("op_handoff_busy", bus.busy, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //            id    cmd    a      b      rslt   z     p     neq
        vecs[0] = '{1'b0, 2'b10, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 2'b00, 8'hF0, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 2'b01, 8'h81, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 2'b01, 8'h02, 8'h02, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 2'b00, 8'h0F, 8'h33, 8'hFC, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 2'b11, 8'h55, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 2'b10, 8'h12, 8'h34, 8'h46, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 2'b00, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};

        bus.req_vld = 2'b00;
        bus.cmd0 = 2'b00; bus.a0 = 8'h00; bus.b0 = 8'h00;
        bus.cmd1 = 2'b00; bus.a1 = 8'h00; bus.b1 = 8'h00;
        bus.rsp_rdy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rsp_vld", bus.rsp_vld, 1'b0);
        chk("rst_req_rdy", bus.req_rdy, 2'b00);
        chk("rst_rsp_id", bus.rsp_id, 1'b0);
        chk("rst_rsp_rslt", bus.rsp_rslt, 8'h00);
        chk("rst_rsp_flags", {bus.rsp_zero, bus.rsp_pari, bus.rsp_neq}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i]);
        end

        // Back-pressure: result held stable, no grants while DONE waits.
        bus.req_vld = 2'b01;
        bus.cmd0 = 2'b10; bus.a0 = 8'hFF; bus.b0 = 8'h01;
        #1;
        chk("stall_req_rdy", bus.req_rdy, 2'b01);
        @(posedge clk); #1;
        bus.req_vld = 2'b10;
        bus.cmd1 = 2'b00; bus.a1 = 8'h0F; bus.b1 = 8'h33;
        chk("stall_exec_rdy", bus.req_rdy, 2'b00);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_vld", bus.rsp_vld, 1'b1);
            chk("stall_rslt", bus.rsp_rslt, 8'h00);
            chk("stall_zero", bus.rsp_zero, 1'b1);
            chk("stall_id", bus.rsp_id, 1'b0);
            chk("stall_req_rdy_done", bus.req_rdy, 2'b00);
            @(posedge clk); #1;
        end
        bus.rsp_rdy = 1'b1;
        @(posedge clk); #1;
        bus.rsp_rdy = 1'b0;
        chk("stall_release_vld", bus.rsp_vld, 1'b0);
        chk("stall_release_busy", bus.busy, 1'b0);
        chk("stall_idle_rdy", bus.req_rdy, 2'b10);
        bus.req_vld = 2'b00;
        @(posedge clk); #1;
        chk("withdraw_busy", bus.busy, 1'b0);

        // Round-robin with both requesters valid from reset.
        rst_n = 1'b0;
        bus.req_vld = 2'b11;
        bus.cmd0 = 2'b10; bus.a0 = 8'h01; bus.b0 = 8'h02;
        bus.cmd1 = 2'b00; bus.a1 = 8'hF0; bus.b1 = 8'hF0;
        bus.rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_req_rdy", bus.req_rdy, (i % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            chk("rr_exec_busy", bus.busy, 1'b1);
            @(posedge clk); #1;
            chk("rr_rsp_vld", bus.rsp_vld, 1'b1);
            chk("rr_rsp_id", bus.rsp_id, (i % 2 == 1) ? 1'b1 : 1'b0);
            chk("rr_rsp_rslt", bus.rsp_rslt, (i % 2 == 1) ? 8'h0F : 8'h03);
            @(posedge clk); #1;
        end
        bus.req_vld = 2'b00;
        bus.rsp_rdy = 1'b0;
        @(posedge clk); #1;

        // Reset during EXEC discards the operation and restores the pointer.
        bus.req_vld = 2'b01;
        bus.cmd0 = 2'b10; bus.a0 = 8'h10; bus.b0 = 8'h20;
        @(posedge clk); #1;
        bus.req_vld = 2'b00;
        chk("mid_rst_pre_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_vld", bus.rsp_vld, 1'b0);
        chk("mid_rst_rslt", bus.rsp_rslt, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("mid_rst_hold_vld", bus.rsp_vld, 1'b0);
        end
        rst_n = 1'b1;
        bus.req_vld = 2'b11;
        bus.cmd0 = 2'b10; bus.a0 = 8'h20; bus.b0 = 8'h05;
        bus.cmd1 = 2'b00; bus.a1 = 8'hFF; bus.b1 = 8'hFF;
        #1;
        chk("post_rst_ptr", bus.req_rdy, 2'b01);
        @(posedge clk); #1;
        bus.req_vld = 2'b00;
        @(posedge clk); #1;
        chk("post_rst_vld", bus.rsp_vld, 1'b1);
        chk("post_rst_id", bus.rsp_id, 1'b0);
        chk("post_rst_rslt", bus.rsp_rslt, 8'h25);
        chk("post_rst_pari", bus.rsp_pari, 1'b1);
        bus.rsp_rdy = 1'b1;
        @(posedge clk); #1;
        bus.rsp_rdy = 1'b0;
        chk("post_rst_done", bus.rsp_vld, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
